// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver with clock glitch filter, odd-parity check,
// mid-frame inactivity timeout, per-frame error pulses and a show-ahead FIFO.
module ps2_rx_fifo #(
  parameter int FIFO_DEPTH     = 8,
  parameter int FILTER_LEN     = 4,
  parameter int TIMEOUT_CYCLES = 50000,
  parameter bit CHECK_PARITY   = 1'b1
) (
  input  logic                               i_clk,
  input  logic                               i_rst,
  input  logic                               i_ps2_clk,
  input  logic                               i_ps2_data,
  output logic [7:0]                         o_rd_data,
  output logic                               o_rd_valid,
  input  logic                               i_rd_en,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    o_fifo_count,
  output logic                               o_parity_err,
  output logic                               o_frame_err,
  output logic                               o_timeout_err,
  output logic                               o_overflow
);

  // state  | meaning
  // IDLE   | waiting for a start bit (fall with data=0)
  // DATA   | shifting in 8 data bits, LSB first
  // PARITY | capturing the parity bit
  // STOP   | stop-bit fall closes the frame and decides push / error
  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [3:0]    FLT_TC   = 4'(FILTER_LEN - 1);
  localparam logic [TW-1:0] TO_TC    = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

  logic          r_clk_s1, r_clk_s2, r_dat_s1, r_dat_s2;
  logic          r_flt_lvl;
  logic [3:0]    r_flt_cnt;
  logic          w_flt_flip, w_fall;

  state_t        r_state, w_state_nxt;
  logic [2:0]    r_bit_cnt;
  logic [7:0]    r_shift;
  logic          r_par;
  logic [TW-1:0] r_to_cnt;
  logic          w_to_expired, w_par_ok;
  logic          w_push, w_frame_err_nxt, w_parity_err_nxt, w_timeout_nxt, w_overflow_nxt;
  logic          r_parity_err, r_frame_err, r_timeout_err, r_overflow;

  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          w_pop, w_full;

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_clk_s1  <= 1'b1;
      r_clk_s2  <= 1'b1;
      r_dat_s1  <= 1'b1;
      r_dat_s2  <= 1'b1;
      r_flt_lvl <= 1'b1;
      r_flt_cnt <= '0;
    end else begin
      r_clk_s1 <= i_ps2_clk;
      r_clk_s2 <= r_clk_s1;
      r_dat_s1 <= i_ps2_data;
      r_dat_s2 <= r_dat_s1;
      if (w_flt_flip) begin
        r_flt_lvl <= r_clk_s2;
        r_flt_cnt <= '0;
      end else if (r_clk_s2 != r_flt_lvl) begin
        r_flt_cnt <= r_flt_cnt + 4'd1;
      end else begin
        r_flt_cnt <= '0;
      end
    end
  end

  // the level flips on the FILTER_LEN-th consecutive differing sample
  assign w_flt_flip   = (r_clk_s2 != r_flt_lvl) && (r_flt_cnt == FLT_TC);
  assign w_fall       = w_flt_flip && r_flt_lvl;
  assign w_to_expired = (r_to_cnt == TO_TC);
  assign w_par_ok     = ^{r_shift, r_par};
  assign w_pop        = i_rd_en && (r_count != '0);
  assign w_full       = (r_count == FULL_CNT);

  always_comb begin
    w_state_nxt      = r_state;
    w_push           = 1'b0;
    w_frame_err_nxt  = 1'b0;
    w_parity_err_nxt = 1'b0;
    w_timeout_nxt    = 1'b0;
    w_overflow_nxt   = 1'b0;
    case (r_state)
      S_IDLE:   if (w_fall && !r_dat_s2) w_state_nxt = S_DATA;
      S_DATA:   if (w_fall && r_bit_cnt == 3'd7) w_state_nxt = S_PARITY;
      S_PARITY: if (w_fall) w_state_nxt = S_STOP;
      S_STOP: begin
        if (w_fall) begin
          w_state_nxt = S_IDLE;
          if (!r_dat_s2)                      w_frame_err_nxt  = 1'b1;
          else if (CHECK_PARITY && !w_par_ok) w_parity_err_nxt = 1'b1;
          else if (w_full && !w_pop)          w_overflow_nxt   = 1'b1;
          else                                w_push           = 1'b1;
        end
      end
      default:  w_state_nxt = S_IDLE;
    endcase
    // a fall in the expiry cycle keeps the frame alive
    if (r_state != S_IDLE && !w_fall && w_to_expired) begin
      w_state_nxt   = S_IDLE;
      w_timeout_nxt = 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_state       <= S_IDLE;
      r_bit_cnt     <= '0;
      r_shift       <= '0;
      r_par         <= 1'b0;
      r_to_cnt      <= '0;
      r_parity_err  <= 1'b0;
      r_frame_err   <= 1'b0;
      r_timeout_err <= 1'b0;
      r_overflow    <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_parity_err  <= w_parity_err_nxt;
      r_frame_err   <= w_frame_err_nxt;
      r_timeout_err <= w_timeout_nxt;
      r_overflow    <= w_overflow_nxt;
      if (r_state == S_IDLE || w_fall || w_state_nxt == S_IDLE) r_to_cnt <= '0;
      else                                                      r_to_cnt <= r_to_cnt + 1'b1;
      if (w_fall) begin
        case (r_state)
          S_IDLE:   r_bit_cnt <= '0;
          S_DATA: begin
            r_shift   <= {r_dat_s2, r_shift[7:1]};
            r_bit_cnt <= r_bit_cnt + 3'd1;
          end
          S_PARITY: r_par <= r_dat_s2;
          default:  ;
        endcase
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst && w_push) r_mem[r_wr_ptr] <= r_shift;
  end

  assign o_rd_valid    = (r_count != '0);
  assign o_rd_data     = o_rd_valid ? r_mem[r_rd_ptr] : 8'h00;
  assign o_fifo_count  = r_count;
  assign o_parity_err  = r_parity_err;
  assign o_frame_err   = r_frame_err;
  assign o_timeout_err = r_timeout_err;
  assign o_overflow    = r_overflow;

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Directed bench for ps2_rx_fifo: two instances share the PS/2 pins and rd_en,
// one checking parity and one ignoring it.
module tb_ps2_rx_fifo;

  localparam int LAT    = 6;     // 2 sync + FILTER_LEN
  localparam int TO_LAT = 206;   // LAT + TIMEOUT_CYCLES

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       rd_en = 1'b0;

  logic [7:0] rd_data, rd_data2;
  logic       rd_valid, rd_valid2;
  logic [2:0] fifo_count, fifo_count2;
  logic       parity_err, frame_err, timeout_err, overflow;
  logic       parity_err2, frame_err2, timeout_err2, overflow2;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int last_fall = 0;
  int par_n = 0, frm_n = 0, to_n = 0, ovf_n = 0, par2_n = 0;
  int par_cyc = 0, frm_cyc = 0, to_cyc = 0, ovf_cyc = 0, rise_cyc = 0;
  logic valid_q = 1'b0;
  int snap_count = 0, snap_data = 0;

  ps2_rx_fifo #(.FIFO_DEPTH(4), .FILTER_LEN(4), .TIMEOUT_CYCLES(200), .CHECK_PARITY(1'b1)) u_dut (
    .i_clk(clk), .i_rst(rst_n), .i_ps2_clk(ps2_clk), .i_ps2_data(ps2_data),
    .o_rd_data(rd_data), .o_rd_valid(rd_valid), .i_rd_en(rd_en), .o_fifo_count(fifo_count),
    .o_parity_err(parity_err), .o_frame_err(frame_err), .o_timeout_err(timeout_err),
    .o_overflow(overflow));

  ps2_rx_fifo #(.FIFO_DEPTH(4), .FILTER_LEN(4), .TIMEOUT_CYCLES(200), .CHECK_PARITY(1'b0)) u_dut_np (
    .i_clk(clk), .i_rst(rst_n), .i_ps2_clk(ps2_clk), .i_ps2_data(ps2_data),
    .o_rd_data(rd_data2), .o_rd_valid(rd_valid2), .i_rd_en(rd_en), .o_fifo_count(fifo_count2),
    .o_parity_err(parity_err2), .o_frame_err(frame_err2), .o_timeout_err(timeout_err2),
    .o_overflow(overflow2));

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (parity_err)  begin par_n++; par_cyc = cyc; end
    if (frame_err)   begin frm_n++; frm_cyc = cyc; end
    if (timeout_err) begin to_n++;  to_cyc  = cyc; end
    if (overflow)    begin ovf_n++; ovf_cyc = cyc; end
    if (parity_err2) par2_n++;
    if (rd_valid && !valid_q) rise_cyc = cyc;
    valid_q = rd_valid;
  end

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic odd_par(input logic [7:0] d);
    return ~(^d);
  endfunction

  function automatic int err_sum();
    return par_n + frm_n + to_n + ovf_n;
  endfunction

  // one PS/2 bit: 20 cycles high, fall, 40 low, 20 high
  task automatic ps2_bit(input logic b, input bit glitch, input bit pop_at_fall);
    ps2_data = b;
    repeat (5) @(negedge clk);
    if (glitch) begin
      ps2_clk = 1'b0;
      repeat (3) @(negedge clk);
      ps2_clk = 1'b1;
      repeat (12) @(negedge clk);
    end else begin
      repeat (15) @(negedge clk);
    end
    ps2_clk   = 1'b0;
    last_fall = cyc;
    if (pop_at_fall) begin
      repeat (LAT - 1) @(negedge clk);
      rd_en = 1'b1;
      @(negedge clk);
      rd_en      = 1'b0;
      snap_count = int'(fifo_count);
      snap_data  = int'(rd_data);
      repeat (40 - LAT) @(negedge clk);
    end else begin
      repeat (40) @(negedge clk);
    end
    ps2_clk = 1'b1;
    repeat (20) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par, input logic stop,
                            input int nbits, input bit glitch, input bit pop_at_stop);
    logic [10:0] bits;
    bits = {stop, par, d, 1'b0};
    for (int i = 0; i < nbits; i++) ps2_bit(bits[i], glitch, pop_at_stop && (i == 10));
  endtask

  task automatic pop();
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
  endtask

  initial begin
    int e0;
    repeat (3) @(negedge clk);
    check_eq("rst_valid", int'(rd_valid), 0);
    check_eq("rst_data", int'(rd_data), 0);
    check_eq("rst_count", int'(fifo_count), 0);
    check_eq("rst_pulses", int'({parity_err, frame_err, timeout_err, overflow}), 0);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);

    // good frame
    send_frame(8'h1C, 1'b0, 1'b1, 11, 1'b0, 1'b0);
    check_eq("good_latency", rise_cyc - last_fall, LAT);
    check_eq("good_data", int'(rd_data), 8'h1C);
    check_eq("good_count", int'(fifo_count), 1);
    check_eq("good_no_err", err_sum(), 0);
    pop();
    check_eq("good_pop_valid", int'(rd_valid), 0);

    // bad parity: discarded with check, accepted without
    e0 = par_n;
    send_frame(8'hF0, 1'b0, 1'b1, 11, 1'b0, 1'b0);
    check_eq("par_pulses", par_n - e0, 1);
    check_eq("par_latency", par_cyc - last_fall, LAT);
    check_eq("par_count", int'(fifo_count), 0);
    check_eq("nopar_data", int'(rd_data2), 8'hF0);
    check_eq("nopar_count", int'(fifo_count2), 1);
    check_eq("nopar_no_err", par2_n, 0);
    pop();
    check_eq("pop_empty_count", int'(fifo_count), 0);
    check_eq("nopar_pop_count", int'(fifo_count2), 0);

    // stop bit 0
    e0 = frm_n;
    send_frame(8'h1C, 1'b0, 1'b0, 11, 1'b0, 1'b0);
    check_eq("frm_pulses", frm_n - e0, 1);
    check_eq("frm_latency", frm_cyc - last_fall, LAT);
    check_eq("frm_count", int'(fifo_count), 0);

    // timeout on a truncated frame
    send_frame(8'h1C, 1'b0, 1'b1, 11, 1'b0, 1'b0);
    e0 = to_n;
    send_frame(8'h32, 1'b0, 1'b1, 5, 1'b0, 1'b0);
    repeat (300) @(negedge clk);
    check_eq("to_pulses", to_n - e0, 1);
    check_eq("to_latency", to_cyc - last_fall, TO_LAT);
    check_eq("to_count_mid", int'(fifo_count), 1);
    send_frame(8'h2A, 1'b0, 1'b1, 11, 1'b0, 1'b0);
    check_eq("to_count", int'(fifo_count), 2);
    check_eq("to_head0", int'(rd_data), 8'h1C);
    pop();
    check_eq("to_head1", int'(rd_data), 8'h2A);
    pop();
    check_eq("to_drained", int'(rd_valid), 0);

    // overflow
    e0 = ovf_n;
    for (int i = 1; i <= 5; i++) begin
      send_frame(8'(i), odd_par(8'(i)), 1'b1, 11, 1'b0, 1'b0);
      if (i == 4) check_eq("ovf_none_at_4", ovf_n - e0, 0);
    end
    check_eq("ovf_pulses", ovf_n - e0, 1);
    check_eq("ovf_latency", ovf_cyc - last_fall, LAT);
    check_eq("ovf_count", int'(fifo_count), 4);
    for (int i = 1; i <= 4; i++) begin
      check_eq("ovf_pop_data", int'(rd_data), i);
      pop();
    end
    check_eq("ovf_drained", int'(rd_valid), 0);

    // push and pop together while full
    for (int i = 8'h11; i <= 8'h14; i++) send_frame(8'(i), odd_par(8'(i)), 1'b1, 11, 1'b0, 1'b0);
    e0 = ovf_n;
    send_frame(8'h15, odd_par(8'h15), 1'b1, 11, 1'b0, 1'b1);
    check_eq("fullpp_count", snap_count, 4);
    check_eq("fullpp_head", snap_data, 8'h12);
    check_eq("fullpp_no_ovf", ovf_n - e0, 0);
    for (int i = 8'h12; i <= 8'h15; i++) begin
      check_eq("fullpp_pop_data", int'(rd_data), i);
      pop();
    end
    check_eq("fullpp_drained", int'(rd_valid), 0);

    // glitches on ps2_clk are filtered out
    e0 = err_sum();
    ps2_data = 1'b0;
    for (int k = 0; k < 3; k++) begin
      ps2_clk = 1'b0;
      repeat (3) @(negedge clk);
      ps2_clk = 1'b1;
      repeat (17) @(negedge clk);
    end
    ps2_data = 1'b1;
    repeat (250) @(negedge clk);
    check_eq("glitch_idle_count", int'(fifo_count), 0);
    check_eq("glitch_idle_err", err_sum() - e0, 0);
    send_frame(8'h1C, 1'b0, 1'b1, 11, 1'b1, 1'b0);
    check_eq("glitch_data", int'(rd_data), 8'h1C);
    check_eq("glitch_count", int'(fifo_count), 1);
    check_eq("glitch_err", err_sum() - e0, 0);

    // reset mid-frame
    send_frame(8'h55, 1'b1, 1'b1, 4, 1'b0, 1'b0);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("mrst_valid", int'(rd_valid), 0);
    check_eq("mrst_data", int'(rd_data), 0);
    check_eq("mrst_count", int'(fifo_count), 0);
    rst_n = 1'b1;
    repeat (300) @(negedge clk);
    check_eq("mrst_no_err", err_sum() - e0, 0);
    send_frame(8'h1C, 1'b0, 1'b1, 11, 1'b0, 1'b0);
    check_eq("mrst_latency", rise_cyc - last_fall, LAT);
    check_eq("mrst_data_after", int'(rd_data), 8'h1C);
    check_eq("mrst_count_after", int'(fifo_count), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
